// File: rtl/tone_sample_gen.sv
// rtl/tone_sample_gen.sv - square-wave tone sample source feeding an audio codec write port
module tone_sample_gen #(
    parameter logic [23:0] AMP = 24'h100000,
    parameter int          W   = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] period,
    input  logic         enable,
    input  logic         write_ready,
    output logic         write,
    output logic [23:0]  writedata_left,
    output logic [23:0]  writedata_right,
    output logic         half_tick,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [23:0] NEG_AMP = ~AMP + 24'd1;

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] per_l_q, per_l_d;
    logic         phase_q, phase_d;     // 1 = HIGH half-wave, 0 = LOW half-wave
    logic [23:0]  wdata_q, wdata_d;
    logic         half_tick_q, half_tick_d;

    logic [W-1:0] eff_period;
    logic         accept;
    logic         at_end;

    // A zero period would never reach its boundary, so it is treated as one sample.
    assign eff_period = (period == '0) ? W'(1) : period;

    assign write  = (state_q != S_IDLE) && write_ready;
    assign accept = write;
    assign at_end = (cnt_q == (per_l_q - W'(1)));

    // Next-state logic: counter, phase and latched period only move on an accepted sample.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        per_l_d     = per_l_q;
        phase_d     = phase_q;
        half_tick_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    phase_d = 1'b1;
                    per_l_d = eff_period;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (at_end) begin
                        cnt_d       = '0;
                        per_l_d     = eff_period;
                        phase_d     = ~phase_q;
                        half_tick_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + W'(1);
                    end
                end
                if (!enable) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The half-wave in flight is finished, then the tone stops on its boundary.
                if (accept && at_end) begin
                    cnt_d   = '0;
                    per_l_d = eff_period;
                    phase_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    if (accept) begin
                        cnt_d = cnt_q + W'(1);
                    end
                    if (enable) begin
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                phase_d = 1'b1;
                per_l_d = W'(1);
            end
        endcase

        if (state_d == S_IDLE) begin
            wdata_d = 24'd0;
        end else if (phase_d) begin
            wdata_d = AMP;
        end else begin
            wdata_d = NEG_AMP;
        end
    end

    // State register with synchronous reset taking precedence over all inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            per_l_q     <= W'(1);
            phase_q     <= 1'b1;
            wdata_q     <= 24'd0;
            half_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            per_l_q     <= per_l_d;
            phase_q     <= phase_d;
            wdata_q     <= wdata_d;
            half_tick_q <= half_tick_d;
        end
    end

    assign writedata_left  = wdata_q;
    assign writedata_right = wdata_q;
    assign half_tick       = half_tick_q;
    assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_tone_sample_gen.sv
// tb/tb_tone_sample_gen.sv - directed self-checking bench for tone_sample_gen
module tb_tone_sample_gen;

    localparam logic [23:0] POS = 24'h100000;
    localparam logic [23:0] NEG = 24'hF00000;

    logic        clk;
    logic        reset;
    logic [23:0] period;
    logic        enable;
    logic        write_ready;
    logic        write;
    logic [23:0] writedata_left;
    logic [23:0] writedata_right;
    logic        half_tick;
    logic        busy;

    int n_vec;
    int n_err;

    tone_sample_gen dut (
        .clk             (clk),
        .reset           (reset),
        .period          (period),
        .enable          (enable),
        .write_ready     (write_ready),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .half_tick       (half_tick),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [23:0] exp_c [7];

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset       = 1'b1;
        period      = 24'd3;
        enable      = 1'b0;
        write_ready = 1'b0;
        step();
        step();
        reset       = 1'b0;
        write_ready = 1'b1;
        #1;
        chk("rst_busy", 24'(busy), 24'd0);
        chk("rst_write", 24'(write), 24'd0);
        chk("rst_wdata", writedata_left, 24'd0);
        chk("rst_half_tick", 24'(half_tick), 24'd0);

        // Continuous ready, period 3
        enable = 1'b1;
        step();
        for (int k = 0; k < 9; k++) begin
            chk("p3_wdata", writedata_left, (k < 3 || k >= 6) ? POS : NEG);
            chk("p3_right", writedata_right, (k < 3 || k >= 6) ? POS : NEG);
            chk("p3_write", 24'(write), 24'd1);
            chk("p3_half_tick", 24'(half_tick), (k == 3 || k == 6) ? 24'd1 : 24'd0);
            step();
        end
        do_reset();

        // Ready on every 5th cycle, period 4
        period      = 24'd4;
        write_ready = 1'b0;
        enable      = 1'b1;
        step();
        for (int i = 0; i < 25; i++) begin
            write_ready = ((i % 5) == 4);
            #1;
            chk("pulse_wdata", writedata_left, (i < 20) ? POS : NEG);
            chk("pulse_write", 24'(write), 24'(write_ready));
            chk("pulse_half_tick", 24'(half_tick), (i == 20) ? 24'd1 : 24'd0);
            step();
        end
        do_reset();

        // Period change 4 -> 2 after the first accept of a half-wave
        period      = 24'd4;
        write_ready = 1'b1;
        enable      = 1'b1;
        exp_c[0] = POS; exp_c[1] = POS; exp_c[2] = POS; exp_c[3] = POS;
        exp_c[4] = NEG; exp_c[5] = NEG; exp_c[6] = POS;
        step();
        chk("pchg_wdata", writedata_left, exp_c[0]);
        step();
        period = 24'd2;
        for (int k = 1; k < 7; k++) begin
            chk("pchg_wdata", writedata_left, exp_c[k]);
            step();
        end
        do_reset();

        // Enable dropped after one accept: finish half-wave then idle
        period = 24'd3;
        enable = 1'b1;
        step();
        step();
        enable = 1'b0;
        #1;
        chk("drain_busy1", 24'(busy), 24'd1);
        chk("drain_wdata1", writedata_left, POS);
        step();
        chk("drain_busy2", 24'(busy), 24'd1);
        chk("drain_wdata2", writedata_left, POS);
        step();
        chk("drain_busy3", 24'(busy), 24'd0);
        chk("drain_wdata3", writedata_left, 24'd0);
        chk("drain_write3", 24'(write), 24'd0);
        chk("drain_half_tick3", 24'(half_tick), 24'd0);

        // Period 0 behaves as period 1
        period = 24'd0;
        enable = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            chk("p0_wdata", writedata_left, (k % 2 == 0) ? POS : NEG);
            chk("p0_half_tick", 24'(half_tick), (k == 0) ? 24'd0 : 24'd1);
            step();
        end
        do_reset();

        // Reset mid half-wave, then restart with a full half-wave
        period = 24'd3;
        enable = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        chk("mid_rst_write", 24'(write), 24'd0);
        chk("mid_rst_wdata", writedata_left, 24'd0);
        chk("mid_rst_busy", 24'(busy), 24'd0);
        reset = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("restart_wdata", writedata_left, (k < 3) ? POS : NEG);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tone_sample_gen.md
TONE_SAMPLE_GEN -- requirements
Module: tone_sample_gen

Interface
REQ-001 Parameter AMP, default 24'h100000, positive square-wave amplitude (two's complement, 24-bit).
REQ-002 Parameter W, default 24, width of the period input and internal counter.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 period  input  W  half-wave length in accepted samples; driven by the period-adjust stage.
REQ-006 enable  input  1  level; request tone output.
REQ-007 write_ready  input  1  audio codec can accept a sample this cycle.
REQ-008 write  output  1  sample offered to codec; a sample is accepted when write and write_ready are both 1.
REQ-009 writedata_left  output  24  current sample, left channel.
REQ-010 writedata_right  output  24  current sample, right channel, always equal to writedata_left.
REQ-011 half_tick  output  1  one-cycle strobe on each half-wave boundary.
REQ-012 busy  output  1  1 when the state is not IDLE.

Function
REQ-013 The block SHALL implement three states: IDLE, RUN and DRAIN.
REQ-014 IDLE: write=0, writedata=0, half_tick=0; enable=1 -> RUN next cycle, cnt<=0, phase<=HIGH, per_l<=eff(period).
REQ-015 eff(p) SHALL be p when p>=1 and 1 when p==0.
REQ-016 write SHALL equal write_ready when the state is RUN or DRAIN, and 0 otherwise; write is combinational.
REQ-017 writedata SHALL be registered: +AMP when phase=HIGH, -AMP (two's complement) when phase=LOW, 0 in IDLE.
REQ-018 On accept with cnt != per_l-1: cnt<=cnt+1, with no other change.
REQ-019 On accept with cnt == per_l-1 (boundary): cnt<=0, half_tick=1 on the following cycle only, per_l<=eff(period).
REQ-020 At a boundary in RUN: phase SHALL toggle.
REQ-021 At a boundary in DRAIN: the block SHALL go to IDLE, phase<=HIGH, and writedata SHALL be 0 from the next cycle.
REQ-022 A period change SHALL take effect only at a half-wave boundary; mid-half-wave changes SHALL be held off until then.
REQ-023 RUN with enable=0 -> DRAIN; DRAIN with enable=1 -> RUN; cnt and phase SHALL be preserved across both transitions.
REQ-024 A boundary in the same cycle as an enable change SHALL use the state before that edge: RUN toggles phase, DRAIN goes to IDLE.
REQ-025 When write_ready=0, cnt, phase and writedata SHALL hold.
REQ-026 cnt SHALL never exceed per_l-1 and SHALL never wrap past it.
REQ-027 With per_l=1, phase SHALL toggle on every accepted sample.

Reset
REQ-028 reset=1 at a clock edge SHALL, regardless of state, give the following from the next cycle:
- state=IDLE, cnt=0, phase=HIGH, per_l=1
- write=0, writedata_left/right=0, half_tick=0, busy=0
REQ-029 Reset SHALL take precedence over enable and write_ready, including a reset asserted mid half-wave.

Verification
REQ-030 Stimulus: period=3, enable=1, write_ready=1 constantly -> writedata sequence +AMP x3, -AMP x3, +AMP x3; half_tick every 3rd accept.
REQ-031 Stimulus: period=4, write_ready pulsed every 5th cycle -> half-wave lasts 4 accepts (20 cycles); writedata stable between accepts.
REQ-032 Stimulus: period changed 4->2 after 1 accept of a half-wave -> that half-wave completes at 4 accepts, the next lasts 2.
REQ-033 Stimulus: enable dropped after 1 accept with period=3 -> busy stays 1 for 2 more accepts, then IDLE with writedata=0; no phase toggle.
REQ-034 Stimulus: period=0 -> behaves as period=1, alternating +AMP/-AMP on every accept.
REQ-035 Stimulus: reset asserted mid half-wave -> next cycle write=0, writedata=0, busy=0; re-enable starts at +AMP with a full half-wave.
